// File: rtl/des_arb_pkg.sv
// Shared types and widths for the DES engine arbiter.
package des_arb_pkg;

  localparam int DES_BLOCK_W = 64;
  localparam int DES_KEY_W   = 64;
  localparam int TMO_CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/des_rr_arbiter.sv
// 2-way round-robin grant; the pointer moves past the owner once its
// transaction completes.
module des_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  input  logic       owner_i,
  output logic [1:0] grant_o
);

  logic ptr_q, ptr_d;

  // Grant decode: a lone requester wins, a tie goes to the pointer.
  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  // Next pointer value.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = ~owner_i;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/des_engine_arbiter.sv
// Shares one DES engine between two requesters (IDLE/ISSUE/WAIT/RESP FSM).
// Optional engine watchdog: define DES_ARB_TIMEOUT_EN.
module des_engine_arbiter
  import des_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_valid,
  input  logic                   req1_valid,
  output logic                   req0_ready,
  output logic                   req1_ready,
  input  logic [DES_BLOCK_W-1:0] req0_data,
  input  logic [DES_BLOCK_W-1:0] req1_data,
  input  logic [DES_KEY_W-1:0]   req0_key,
  input  logic [DES_KEY_W-1:0]   req1_key,
  input  logic                   req0_decrypt,
  input  logic                   req1_decrypt,
  output logic                   rsp0_valid,
  output logic                   rsp1_valid,
  input  logic                   rsp0_ready,
  input  logic                   rsp1_ready,
  output logic [DES_BLOCK_W-1:0] rsp0_data,
  output logic [DES_BLOCK_W-1:0] rsp1_data,
  output logic                   rsp0_err,
  output logic                   rsp1_err,
  output logic                   eng_start,
  output logic [DES_BLOCK_W-1:0] eng_data,
  output logic [DES_KEY_W-1:0]   eng_key,
  output logic                   eng_decrypt,
  input  logic                   eng_ready,
  input  logic                   eng_done,
  input  logic [DES_BLOCK_W-1:0] eng_result
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << TMO_CNT_W)) begin : g_bad_timeout
    $error("des_engine_arbiter: TIMEOUT_CYCLES out of range");
  end

  arb_state_e                   state_q, state_d;
  logic                         owner_q, owner_d;
  logic [DES_BLOCK_W-1:0]       data_q, data_d;
  logic [DES_KEY_W-1:0]         key_q, key_d;
  logic                         dec_q, dec_d;
  logic [1:0][DES_BLOCK_W-1:0]  rsp_data_q, rsp_data_d;
  logic [1:0]                   rsp_valid_q, rsp_valid_d;
  logic [1:0]                   req_valid, grant, rsp_ready;
  logic                         accept, advance;

`ifdef DES_ARB_TIMEOUT_EN
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);
  logic [1:0]           err_q, err_d;
  logic [TMO_CNT_W-1:0] cnt_q, cnt_d;
`endif

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign accept    = (state_q == IDLE) && (grant != 2'b00);
  assign advance   = (state_q == RESP) && rsp_ready[owner_q];

  des_rr_arbiter u_rr (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req_valid),
    .advance_i (advance),
    .owner_i   (owner_q),
    .grant_o   (grant)
  );

  // Next-state and datapath capture.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    data_d      = data_q;
    key_d       = key_q;
    dec_d       = dec_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
`ifdef DES_ARB_TIMEOUT_EN
    err_d       = err_q;
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = grant[1];
          data_d  = grant[1] ? req1_data    : req0_data;
          key_d   = grant[1] ? req1_key     : req0_key;
          dec_d   = grant[1] ? req1_decrypt : req0_decrypt;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (eng_ready) begin
          state_d = WAIT;
`ifdef DES_ARB_TIMEOUT_EN
          cnt_d   = {TMO_CNT_W{1'b0}};
`endif
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT: begin
        if (eng_done) begin
          rsp_data_d[owner_q]  = eng_result;
          rsp_valid_d[owner_q] = 1'b1;
`ifdef DES_ARB_TIMEOUT_EN
          err_d[owner_q]       = 1'b0;
`endif
          state_d              = RESP;
        end
`ifdef DES_ARB_TIMEOUT_EN
        // Watchdog expiry reports an error with a zeroed block.
        else if (cnt_q == TMO_LAST) begin
          rsp_data_d[owner_q]  = {DES_BLOCK_W{1'b0}};
          rsp_valid_d[owner_q] = 1'b1;
          err_d[owner_q]       = 1'b1;
          state_d              = RESP;
        end else begin
          cnt_d = cnt_q + TMO_CNT_W'(1);
        end
`else
        else begin
          state_d = WAIT;
        end
`endif
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          rsp_valid_d[owner_q] = 1'b0;
          state_d              = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and capture registers; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      data_q      <= {DES_BLOCK_W{1'b0}};
      key_q       <= {DES_KEY_W{1'b0}};
      dec_q       <= 1'b0;
      rsp_data_q  <= {2*DES_BLOCK_W{1'b0}};
      rsp_valid_q <= 2'b00;
`ifdef DES_ARB_TIMEOUT_EN
      err_q       <= 2'b00;
      cnt_q       <= {TMO_CNT_W{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      data_q      <= data_d;
      key_q       <= key_d;
      dec_q       <= dec_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef DES_ARB_TIMEOUT_EN
      err_q       <= err_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign req0_ready  = (state_q == IDLE) && grant[0];
  assign req1_ready  = (state_q == IDLE) && grant[1];
  assign eng_start   = (state_q == ISSUE) && eng_ready;
  assign eng_data    = data_q;
  assign eng_key     = key_q;
  assign eng_decrypt = dec_q;
  assign rsp0_valid  = rsp_valid_q[0];
  assign rsp1_valid  = rsp_valid_q[1];
  assign rsp0_data   = rsp_data_q[0];
  assign rsp1_data   = rsp_data_q[1];
`ifdef DES_ARB_TIMEOUT_EN
  assign rsp0_err    = err_q[0];
  assign rsp1_err    = err_q[1];
`else
  assign rsp0_err    = 1'b0;
  assign rsp1_err    = 1'b0;
`endif

endmodule
